dcache_ctrl: RTL and testbench

//   Direct-mapped, write-back, write-allocate data cache with its miss-sequencing FSM, in the MEM stage.

---
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
//----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache for the MEM stage.
//   Loads and stores that hit finish in the cycle they are issued. A miss
//   raises cpu_stall_o, which freezes every pipeline register and the PC.
//   The miss FSM then writes back a dirty victim line if there is one,
//   refills the line from off-chip memory, and releases the stall as soon as
//   the access hits.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous reset, active-high
//   cpu_read_i   load request (EX/MEM MemRead)
//   cpu_write_i  store request (EX/MEM MemWrite)
//   cpu_addr_i   word-aligned byte address
//   cpu_wdata_i  store data
//   cpu_rdata_o  load data; zero unless this cycle is a read hit
//   cpu_stall_o  pipeline-wide stall (request and not hit)
//   mem_enable_o memory request, held until mem_ack_i
//   mem_write_o  1 = write back victim line, 0 = line fill
//   mem_addr_o   line-aligned memory address
//   mem_wdata_o  victim line for the write back
//   mem_rdata_i  fill line, sampled in the mem_ack_i cycle
//   mem_ack_i    one-cycle completion pulse from memory
//----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - 5 - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        REFILL
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   addr_tag;
    logic [7:0]         word_lsb;
    logic [LINE_W-1:0]  cur_line;
    logic               req;
    logic               hit;
    logic               write_hit;
    logic               fill_en;

    // The two low address bits are always zero for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Address decode and hit detection.
    assign idx       = cpu_addr_i[5 +: INDEX_W];
    assign addr_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_lsb  = {cpu_addr_i[4:2], 5'b0};
    assign cur_line  = data_q[idx];
    assign req       = cpu_read_i | cpu_write_i;
    assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign write_hit = cpu_write_i && hit;

    // The stall is purely combinational so it drops in the very cycle the
    // refilled line starts to hit (the REFILL cycle).
    assign cpu_stall_o = req && !hit;
    assign cpu_rdata_o = (cpu_read_i && hit) ? cur_line[word_lsb +: 32] : 32'd0;

    // State register. Reset abandons any transaction in flight; because the
    // memory-side outputs decode from state alone, a late ack lands in IDLE
    // and is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory-interface decode. The write-back address is built
    // from the victim's stored tag, the fill address from the requested tag.
    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        fill_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[idx], idx, 5'b0};
                mem_wdata_o  = data_q[idx];
                if (mem_ack_i) begin
                    state_d = READMISS;
                end
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {addr_tag, idx, 5'b0};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid and dirty bits. A fill installs a clean line; a store that hits
    // (including the merged store in REFILL) marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_en) begin
                data_q[idx] <= mem_rdata_i;
                tag_q[idx]  <= addr_tag;
            end else if (write_hit) begin
                data_q[idx][word_lsb +: 32] <= cpu_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
//----------------------------------------------------------------------------
// tb_dcache_ctrl
//   Directed bench for dcache_ctrl. A small backing-memory model supplies
//   fill lines (a fixed pattern per line address unless a line was written
//   back earlier). Single-cycle hit behaviour is driven from vector tables;
//   misses, write backs and the reset-during-refill case are hand sequences.
//----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int vecCount  = 0;
    int missCount = 0;

    logic [255:0] backing [logic [31:0]];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expStall;
        logic [31:0] expRdata;
    } vec_t;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_read_i   (cpu_read_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    // Free-running 10-time-unit clock.
    always #5 clk_i = ~clk_i;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Word i of a never-written line is {16'hA5A5, line address[15:0]} + i.
    function automatic logic [255:0] patternLine(input logic [31:0] lineAddr);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = {16'hA5A5, lineAddr[15:0]} + 32'(i);
        end
        return l;
    endfunction

    function automatic logic [255:0] memLine(input logic [31:0] lineAddr);
        if (backing.exists(lineAddr)) begin
            return backing[lineAddr];
        end
        return patternLine(lineAddr);
    endfunction

    function automatic vec_t mkVec(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic expStall,
                                   input logic [31:0] expRdata);
        vec_t v;
        v.rd       = rd;
        v.wr       = wr;
        v.addr     = addr;
        v.wdata    = wdata;
        v.expStall = expStall;
        v.expRdata = expRdata;
        return v;
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        cpu_read_i  = rd;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One table vector per cycle: drive at the falling edge, check just after.
    task automatic runVector(input string name, input vec_t v);
        @(negedge clk_i);
        applyStimulus(v.rd, v.wr, v.addr, v.wdata);
        #1;
        checkOutput({name, "_stall"}, 256'(cpu_stall_o), 256'(v.expStall));
        checkOutput({name, "_rdata"}, 256'(cpu_rdata_o), 256'(v.expRdata));
        checkOutput({name, "_enable"}, 256'(mem_enable_o), 256'd0);
    endtask

    // Issues a missing access and plays memory: each request phase is acked
    // ackDelay cycles after it starts. Counts stall cycles and checks the
    // write-back and fill addresses/data, then the hit cycle that follows.
    task automatic runAccess(input string name, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ackDelay, input int expStall, input logic expWb,
                             input logic [31:0] wbAddr, input logic [255:0] wbData,
                             input logic [31:0] fillAddr, input logic [31:0] expRdata);
        int   stalls = 0;
        int   k      = 0;
        int   guard  = 0;
        logic sawWb  = 1'b0;
        logic sawFill = 1'b0;
        logic earlyEnable = 1'b0;
        @(negedge clk_i);
        applyStimulus(rd, wr, addr, wdata);
        mem_ack_i = 1'b0;
        #1;
        while (cpu_stall_o && guard < 100) begin
            guard++;
            mem_ack_i = 1'b0;
            if (stalls < 2 && mem_enable_o) begin
                earlyEnable = 1'b1;
            end
            stalls++;
            if (mem_enable_o) begin
                if (mem_write_o && !sawWb) begin
                    sawWb = 1'b1;
                    checkOutput({name, "_wb_addr"}, 256'(mem_addr_o), 256'(wbAddr));
                    checkOutput({name, "_wb_data"}, mem_wdata_o, wbData);
                end
                if (!mem_write_o && !sawFill) begin
                    sawFill = 1'b1;
                    checkOutput({name, "_fill_addr"}, 256'(mem_addr_o), 256'(fillAddr));
                    mem_rdata_i = memLine(fillAddr);
                end
                if (k == ackDelay) begin
                    mem_ack_i = 1'b1;
                    k = 0;
                    if (mem_write_o) begin
                        backing[wbAddr] = wbData;
                    end
                end else begin
                    k++;
                end
            end
            @(negedge clk_i);
            #1;
        end
        mem_ack_i = 1'b0;
        checkOutput({name, "_no_timeout"}, 256'(guard < 100), 256'd1);
        checkOutput({name, "_stall_cycles"}, 256'(stalls), 256'(expStall));
        checkOutput({name, "_writeback_seen"}, 256'(sawWb), 256'(expWb));
        checkOutput({name, "_fill_seen"}, 256'(sawFill), 256'd1);
        checkOutput({name, "_no_early_enable"}, 256'(earlyEnable), 256'd0);
        checkOutput({name, "_enable_dropped"}, 256'(mem_enable_o), 256'd0);
        if (rd) begin
            checkOutput({name, "_rdata"}, 256'(cpu_rdata_o), 256'(expRdata));
        end
    endtask

    // Main test sequence.
    initial begin
        vec_t         tblA [8];
        vec_t         tblB [2];
        vec_t         tblC [3];
        logic [255:0] wbLine;
        logic         found;

        tblA[0] = mkVec(1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 32'hA5A5_0041);
        tblA[1] = mkVec(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, 1'b0, 32'h0);
        tblA[2] = mkVec(1'b1, 1'b0, 32'h48, 32'h0,        1'b0, 32'hDEADBEEF);
        tblA[3] = mkVec(1'b1, 1'b0, 32'h5C, 32'h0,        1'b0, 32'hA5A5_0047);
        tblA[4] = mkVec(1'b0, 1'b1, 32'h4C, 32'h12345678, 1'b0, 32'h0);
        tblA[5] = mkVec(1'b1, 1'b0, 32'h4C, 32'h0,        1'b0, 32'h12345678);
        tblA[6] = mkVec(1'b0, 1'b0, 32'h248, 32'h0,       1'b0, 32'h0);
        tblA[7] = mkVec(1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 32'hA5A5_0040);

        tblB[0] = mkVec(1'b1, 1'b0, 32'h24C, 32'h0, 1'b0, 32'hA5A5_0243);
        tblB[1] = mkVec(1'b1, 1'b0, 32'h240, 32'h0, 1'b0, 32'hA5A5_0240);

        tblC[0] = mkVec(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'hCAFEF00D);
        tblC[1] = mkVec(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'hA5A5_0101);
        tblC[2] = mkVec(1'b1, 1'b0, 32'h4C,  32'h0, 1'b0, 32'h12345678);

        rst_i       = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("reset_stall",  256'(cpu_stall_o),  256'd0);
        checkOutput("reset_enable", 256'(mem_enable_o), 256'd0);
        checkOutput("reset_write",  256'(mem_write_o),  256'd0);
        checkOutput("reset_addr",   256'(mem_addr_o),   256'd0);
        checkOutput("reset_wdata",  mem_wdata_o,        256'd0);
        checkOutput("reset_rdata",  256'(cpu_rdata_o),  256'd0);

        $display("[TB] cold read miss");
        runAccess("cold_rd_40", 1'b1, 1'b0, 32'h40, 32'h0, 4, 7, 1'b0,
                  32'h0, 256'h0, 32'h40, 32'hA5A5_0040);

        $display("[TB] hits and stores on line 0x40");
        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("tblA%0d", i), tblA[i]);
        end

        $display("[TB] conflict miss with dirty victim");
        wbLine = patternLine(32'h40);
        wbLine[95:64]  = 32'hDEADBEEF;
        wbLine[127:96] = 32'h12345678;
        runAccess("dirty_rd_248", 1'b1, 1'b0, 32'h248, 32'h0, 2, 8, 1'b1,
                  32'h40, wbLine, 32'h240, 32'hA5A5_0242);
        for (int i = 0; i < 2; i++) begin
            runVector($sformatf("tblB%0d", i), tblB[i]);
        end

        $display("[TB] refilled line is clean");
        runAccess("clean_rd_48", 1'b1, 1'b0, 32'h48, 32'h0, 1, 4, 1'b0,
                  32'h0, 256'h0, 32'h40, 32'hDEADBEEF);

        $display("[TB] write miss with store merge");
        runAccess("wr_miss_100", 1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 0, 3, 1'b0,
                  32'h0, 256'h0, 32'h100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            runVector($sformatf("tblC%0d", i), tblC[i]);
        end

        wbLine = patternLine(32'h100);
        wbLine[31:0] = 32'hCAFEF00D;
        runAccess("dirty_rd_300", 1'b1, 1'b0, 32'h300, 32'h0, 1, 6, 1'b1,
                  32'h100, wbLine, 32'h300, 32'hA5A5_0300);

        $display("[TB] reset during line fill");
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk_i);
            #1;
            if (mem_enable_o && !mem_write_o) begin
                found = 1'b1;
            end
        end
        checkOutput("rst_reached_readmiss", 256'(found), 256'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("rst_enable", 256'(mem_enable_o), 256'd0);
        checkOutput("rst_stall",  256'(cpu_stall_o),  256'd0);
        checkOutput("rst_addr",   256'(mem_addr_o),   256'd0);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("late_ack_enable", 256'(mem_enable_o), 256'd0);
        checkOutput("late_ack_stall",  256'(cpu_stall_o),  256'd0);

        runAccess("post_rst_rd_300", 1'b1, 1'b0, 32'h300, 32'h0, 1, 4, 1'b0,
                  32'h0, 256'h0, 32'h300, 32'hA5A5_0300);
        runAccess("post_rst_rd_44", 1'b1, 1'b0, 32'h44, 32'h0, 3, 6, 1'b0,
                  32'h0, 256'h0, 32'h40, 32'hA5A5_0041);

        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
